// File: rtl/tc_psum_buf_if.sv
// Bus between the tensor-core datapath and the partial-sum buffer.
// Carries the accumulate slice in and the readout rows out, with no handshake.
interface tc_psum_buf_if #(
  parameter int tileM   = 4,
  parameter int DW_DATA = 8,
  parameter int DW_POS  = 4,
  parameter int DW_OUT  = 128
);
  logic [DW_POS-1:0]        col;
  logic [DW_POS-1:0]        row;
  logic [tileM*DW_DATA-1:0] in;
  logic                     out_en;
  logic                     out_valid;
  logic [DW_OUT-1:0]        out;

  modport master (output col, row, in, out_en, input out_valid, out);
  modport slave  (input col, row, in, out_en, output out_valid, out);
endinterface

// File: rtl/tc_psum_buf.sv
// M x N partial-sum buffer: accumulates a tileM-tall column slice per cycle, reads out
// and clears one row per cycle while out_en is high (latency 1). No backpressure on out.
module tc_psum_buf #(
  parameter int M       = 16,
  parameter int N       = 16,
  parameter int tileM   = 4,
  parameter int DW_DATA = 8,
  parameter int DW_POS  = 4,
  parameter int DW_OUT  = N*DW_DATA
) (
  input logic          clk,
  input logic          rst,
  tc_psum_buf_if.slave bus
);

  typedef enum logic {ACC = 1'b0, READ = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [DW_DATA-1:0]  psum     [M][N];
  logic [DW_DATA-1:0]  psum_nxt [M][N];
  logic [DW_POS-1:0]   rp, rp_nxt;
  logic [DW_OUT-1:0]   out_q, out_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= ACC;
    else      state <= state_nxt;
  end

  // Next state follows the out_en level directly
  always_comb begin
    state_nxt = bus.out_en ? READ : ACC;
  end

  // Outputs: a row was produced on the edge that entered READ
  always_comb begin
    bus.out_valid = (state == READ);
    bus.out       = out_q;
  end

  // Datapath. Constant-index loops keep every array select in range when
  // M or N is smaller than 2**DW_POS; out-of-range col simply matches nothing.
  always_comb begin
    psum_nxt = psum;
    out_nxt  = out_q;
    rp_nxt   = '0;
    if (bus.out_en) begin
      for (int r = 0; r < M; r++) begin
        if (int'(rp) == r) begin
          for (int c = 0; c < N; c++) begin
            out_nxt[c*DW_DATA +: DW_DATA] = psum[r][c];
            psum_nxt[r][c]                = '0;
          end
        end
      end
      rp_nxt = (rp == DW_POS'(M-1)) ? '0 : rp + 1'b1;
    end else begin
      for (int r = 0; r < M; r++) begin
        for (int c = 0; c < N; c++) begin
          if (int'(bus.col) == c) begin
            // Lanes that wrap onto the same row all add in
            for (int i = 0; i < tileM; i++) begin
              if ((int'(bus.row) + i) % M == r)
                psum_nxt[r][c] = psum_nxt[r][c] + bus.in[i*DW_DATA +: DW_DATA];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < M; r++)
        for (int c = 0; c < N; c++)
          psum[r][c] <= '0;
      rp    <= '0;
      out_q <= '0;
    end else begin
      psum  <= psum_nxt;
      rp    <= rp_nxt;
      out_q <= out_nxt;
    end
  end

endmodule

// File: tb/tb_tc_psum_buf.sv
// Directed bench for tc_psum_buf: a 16x16 instance for the main sequence and an
// 8-column instance for out-of-range column writes.
module tb_tc_psum_buf;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] expm [16][16];

  always #5 clk = ~clk;

  tc_psum_buf_if #(.tileM(4), .DW_DATA(8), .DW_POS(4), .DW_OUT(128)) bus ();
  tc_psum_buf_if #(.tileM(4), .DW_DATA(8), .DW_POS(4), .DW_OUT(64))  bus8 ();

  tc_psum_buf #(.M(16), .N(16), .tileM(4), .DW_DATA(8), .DW_POS(4)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  tc_psum_buf #(.M(16), .N(8), .tileM(4), .DW_DATA(8), .DW_POS(4)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_row(input int r);
    logic [127:0] v;
    for (int c = 0; c < 16; c++) v[c*8 +: 8] = expm[r][c];
    return v;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        expm[r][c] = 8'h00;
  endtask

  // Reads n rows starting at row start; leaves out_en high.
  task automatic read_rows(input int n, input int start, input string tag);
    bus.out_en = 1'b1;
    for (int k = 0; k < n; k++) begin
      int r;
      r = (start + k) % 16;
      step();
      chk($sformatf("%s_vld%0d", tag, k), 128'(bus.out_valid), 128'd1);
      chk($sformatf("%s_row%0d", tag, r), bus.out, exp_row(r));
      for (int c = 0; c < 16; c++) expm[r][c] = 8'h00;
    end
  endtask

  initial begin
    logic [127:0] hold_exp;
    bus.col = '0; bus.row = '0; bus.in = '0; bus.out_en = 1'b0;
    bus8.col = '0; bus8.row = '0; bus8.in = '0; bus8.out_en = 1'b0;
    clear_model();

    // Reset, then an all-zero readout
    step(); step();
    chk("rst_out", bus.out, 128'd0);
    chk("rst_vld", 128'(bus.out_valid), 128'd0);
    rst = 1'b1;
    read_rows(16, 0, "t1");
    bus.out_en = 1'b0;
    step();
    chk("t1_vld_drop", 128'(bus.out_valid), 128'd0);

    // Accumulate the same slice five times
    bus.row = 4'd0; bus.col = 4'd0; bus.in = {8'h02, 8'h03, 8'h01, 8'h00};
    repeat (5) step();
    chk("t2_acc_vld", 128'(bus.out_valid), 128'd0);
    bus.in = '0;
    expm[1][0] = 8'h05; expm[2][0] = 8'h0F; expm[3][0] = 8'h0A;
    read_rows(16, 0, "t2");

    // Hold out_en past M rows: everything already cleared
    read_rows(16, 0, "t4");
    bus.out_en = 1'b0;
    step();
    chk("t4_vld_drop", 128'(bus.out_valid), 128'd0);
    bus.row = 4'd5; bus.col = 4'd7; bus.in = {8'h04, 8'h03, 8'h02, 8'h01};
    step();
    bus.in = '0;
    expm[5][7] = 8'h01; expm[6][7] = 8'h02; expm[7][7] = 8'h03; expm[8][7] = 8'h04;
    read_rows(16, 0, "t4b");
    bus.out_en = 1'b0;
    step();

    // Row wrap and 8-bit overflow
    bus.row = 4'd14; bus.col = 4'd3; bus.in = {8'h03, 8'h02, 8'h01, 8'hFF};
    step(); step();
    bus.in = '0;
    expm[14][3] = 8'hFE; expm[15][3] = 8'h02; expm[0][3] = 8'h04; expm[1][3] = 8'h06;
    read_rows(16, 0, "t3");
    bus.out_en = 1'b0;
    step();

    // Partial readout, out holds, second readout restarts at row 0
    bus.row = 4'd0; bus.col = 4'd2; bus.in = {8'h04, 8'h03, 8'h02, 8'h01};
    step();
    bus.in = '0;
    expm[0][2] = 8'h01; expm[1][2] = 8'h02; expm[2][2] = 8'h03; expm[3][2] = 8'h04;
    hold_exp = exp_row(1);
    read_rows(2, 0, "t5a");
    bus.out_en = 1'b0;
    step();
    chk("t5_vld_drop", 128'(bus.out_valid), 128'd0);
    chk("t5_out_hold", bus.out, hold_exp);
    read_rows(16, 0, "t5b");
    bus.out_en = 1'b0;
    step();

    // Reset in the middle of a readout
    bus.row = 4'd0; bus.col = 4'd0; bus.in = {8'h01, 8'h01, 8'h01, 8'h01};
    step();
    bus.in = '0;
    bus.out_en = 1'b1;
    step();
    chk("t7_row0", bus.out, 128'h01);
    rst = 1'b0;
    step();
    chk("t7_rst_out", bus.out, 128'd0);
    chk("t7_rst_vld", 128'(bus.out_valid), 128'd0);
    rst = 1'b1;
    bus.out_en = 1'b0;
    step();
    clear_model();
    read_rows(16, 0, "t7");
    bus.out_en = 1'b0;
    step();

    // N=8 instance: col=9 is dropped, col=7 lands
    bus8.row = 4'd0; bus8.col = 4'd9; bus8.in = {8'h01, 8'h01, 8'h01, 8'h01};
    step(); step();
    bus8.col = 4'd7; bus8.in = {8'h04, 8'h03, 8'h02, 8'h01};
    step();
    bus8.in = '0;
    bus8.out_en = 1'b1;
    for (int r = 0; r < 16; r++) begin
      logic [63:0] e;
      e = (r < 4) ? (64'(r + 1) << 56) : 64'd0;
      step();
      chk($sformatf("t6_vld%0d", r), 128'(bus8.out_valid), 128'd1);
      chk($sformatf("t6_row%0d", r), 128'(bus8.out), 128'(e));
    end
    bus8.out_en = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
